// File: rtl/ssd_scan_ctrl.sv
// Scan controller for a multiplexed common-segment display: one shared hex decoder,
// active-low anodes, guard cycles between digits, frame-synchronous value updates.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int DIV_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  output logic [3:0]              nib,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    ready,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic {GUARD, SHOW} state_t;

  state_t                  state, state_next;
  logic [DIV_W-1:0]        cnt, cnt_next;
  logic [IDX_W-1:0]        digit, digit_next;
  logic [4*NUM_DIGITS-1:0] active_val, shadow_val, commit_val;
  logic [NUM_DIGITS-1:0]   active_dp, shadow_dp;
  logic                    pending;
  logic                    slot_end, frame_end, commit;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;

  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (active_val[4*k +: 4] == 4'h0);
      blank_mask[k] = lz_blank_en & zero_run & (k != 0);
    end
  end

  always_comb begin
    state_next = state;
    digit_next = digit;
    slot_end   = (cnt == DIV_W'(REFRESH_DIV - 1));
    cnt_next   = slot_end ? '0 : cnt + 1'b1;
    case (state)
      GUARD: if (cnt == DIV_W'(BLANK_CYCLES - 1)) state_next = SHOW;
      SHOW: begin
        if (slot_end) begin
          state_next = GUARD;
          digit_next = (digit == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
        end
      end
      default: state_next = GUARD;
    endcase
    frame_end  = (state == SHOW) && slot_end && (digit == IDX_W'(NUM_DIGITS - 1));
    commit     = frame_end && pending;
    commit_val = commit ? shadow_val : active_val;
    an_n       = '1;
    if ((state == SHOW) && !blank_mask[digit]) an_n[digit] = 1'b0;
    frame_done = frame_end;
    ready      = ~pending;
  end

  // nib/dp_n are loaded ahead of the slot so the decoder settles during the guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GUARD;
      cnt        <= '0;
      digit      <= '0;
      active_val <= '0;
      active_dp  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      nib        <= 4'h0;
      dp_n       <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      digit <= digit_next;
      if (commit) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
        pending    <= 1'b0;
      end else if (load && !pending) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
      if (slot_end) nib <= commit_val[4*digit_next +: 4];
      dp_n <= ((state_next == SHOW) && !blank_mask[digit_next]) ? ~active_dp[digit_next] : 1'b1;
    end
  end

endmodule
